multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Multicycle MIPS control unit that sequences each instruction through fetch, decode, execute, memory and writeback states. It drives datapath strobes and mux selects per state, and stalls on a memory ready handshake. It decodes the full integer subset: R-type ALU/shift/jr, andi/ori/slti/addi/addiu/lui, lw/sw, beq/bne/bgtz/bgez, j/jal. A watchdog detects stalled memory, and unknown opcodes raise a sticky fault.

Parameters:
WAIT_LIMIT, 15, max consecutive cycles a memory state waits on mem_ready before entering FAULT; 0 disables the timeout.
CNT_W, 4, width of the wait counter; WAIT_LIMIT must be < 2^CNT_W.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
instruction  in  32  instruction register contents, valid from DECODE onward
mem_ready  in  1  memory completed current read/write this cycle
alu_zero  in  1  ALU result == 0
alu_neg  in  1  ALU result bit 31
IRWrite  out  1  load instruction register
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if branch condition true (condition resolved internally)
PCSource  out  2  00 ALU result, 01 rs (jr), 10 jump target {PC[31:28],imm26,00}, 11 ALUOut (branch target)
IorD  out  1  0 memory address = PC, 1 = ALUOut
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
MemtoReg  out  1  1 writeback from MDR
RegWrite  out  1  register file write
RegDst  out  2  00 rd, 01 rt, 10 $31
ALUSrcA  out  1  0 PC, 1 rs
ALUSrcB  out  3  000 rt, 001 const 4, 010 SignExtImm, 011 SignExtImm<<2, 100 ZeroExtImm, 101 UpperImm, 110 zero
ALU_ctrl  out  4  0000 nop, 0001 add, 0010 sub, 0011 and, 0100 or, 0101 nor, 0110 slt, 0111 sll, 1000 srl, 1001 sra
fault  out  1  sticky error flag
state  out  4  current state, for debug

Behaviour:
- States and encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_MEM=7, WB_ALU=8, BRANCH=9, JUMP=10, FAULT=11.
- Reset: state=FETCH, wait counter=0, fault=0. While rst=1, all strobes are forced 0: IRWrite, PCWrite, PCWriteCond, MemRead, MemWrite, RegWrite. All selects are 0 while rst=1.
- Output decode: outputs are combinational from state and instruction. IRWrite and PCWrite in FETCH also depend on mem_ready. Unlisted outputs are 0 in every state.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=001, ALU_ctrl=add, PCSource=00.
  - mem_ready=1: IRWrite=1, PCWrite=1, go to DECODE.
  - mem_ready=0: stay in FETCH and increment the wait counter.
- DECODE: computes the branch target into ALUOut (ALUSrcA=0, ALUSrcB=011, add). Next state by opcode:
  - R-type → EXEC_R, except jr → JUMP, and nop (all-zero instruction) → FETCH.
  - I-type ALU ops and lui → EXEC_I.
  - lw/sw → MEM_ADDR.
  - beq/bne/bgtz/bgez → BRANCH.
  - j/jal → JUMP.
  - Any other opcode or funct → FAULT.
- EXEC_R: ALUSrcA=1, ALUSrcB=000, ALU_ctrl from funct using the encodings above; addu/subu map to add/sub. Go to WB_ALU.
- EXEC_I: ALUSrcA=1. ALUSrcB and ALU_ctrl per op:
  - andi: 100, and.
  - ori: 100, or.
  - slti: 010, slt.
  - addi/addiu: 010, add.
  - lui: 101, add.
  - Go to WB_ALU.
- WB_ALU: RegWrite=1. RegDst=00 for R-type, 01 for I-type. Go to FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=010, add. Go to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: MemRead=1, IorD=1. Wait for mem_ready, then go to WB_MEM.
- MEM_WR: MemWrite=1, IorD=1. Wait for mem_ready, then go to FETCH.
- WB_MEM: RegWrite=1, MemtoReg=1, RegDst=01. Go to FETCH.
- BRANCH: ALUSrcA=1, ALU_ctrl=sub, PCSource=11. ALUSrcB=000 for beq/bne, 110 for bgtz/bgez. PCWriteCond=1 only when the condition holds:
  - beq: alu_zero.
  - bne: !alu_zero.
  - bgtz: !alu_neg & !alu_zero.
  - bgez: !alu_neg (requires rt field = 00001; otherwise FAULT at DECODE).
  - Go to FETCH.
- JUMP: PCWrite=1.
  - j/jal: PCSource=10. jal also sets RegWrite=1, RegDst=10, ALUSrcA=0, ALUSrcB=110, add, which writes the already-incremented PC+4 to $31.
  - jr: PCSource=01.
  - Go to FETCH.
- Latency with zero wait states, in cycles: R/I-type ALU 4, lw 5, sw 4, branch 3, j/jal/jr 3, nop 2.
- Wait counter: cleared on entry to FETCH, MEM_RD and MEM_WR; increments each cycle mem_ready=0 in those states. When it reaches WAIT_LIMIT with mem_ready still 0 and WAIT_LIMIT≠0, go to FAULT. If mem_ready=1 on the limit cycle, it completes normally.
- FAULT: fault=1, all strobes 0. The state holds until rst.
- Reset asserted mid-instruction: state immediately returns to FETCH, and no partial write completes after rst rises.

Test Plan:
- Reset then add $3,$1,$2 (0x00221820), mem_ready=1 → states 0,1,2,8,0; WB_ALU has RegWrite=1, RegDst=00, ALU_ctrl=0001 in EXEC_R.
- lw $5,8($4) (0x8C850008), mem_ready low 3 cycles in MEM_RD → MEM_RD held 4 cycles, then WB_MEM with MemtoReg=1, RegDst=01; total 8 cycles.
- beq, first with alu_zero=1 then with alu_zero=0 → PCWriteCond=1 and PCSource=11 in BRANCH for the first, PCWriteCond=0 for the second; bgtz with alu_neg=1 → not taken.
- jal 0x0100000 (0x0C100000) → JUMP asserts PCWrite=1, PCSource=10, RegWrite=1, RegDst=10; returns to FETCH after 3 cycles.
- WAIT_LIMIT=15, mem_ready held 0 in FETCH → state=11 and fault=1 after 15 wait cycles; stays until rst. Opcode 0x3F → FAULT at DECODE.
- Assert rst during MEM_WR → MemWrite drops the same cycle; state=0 and fault=0 after release.

Source files
------------

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Control FSM for a multicycle MIPS integer datapath. Every instruction passes
// through FETCH and DECODE. It then takes the execute, memory and writeback
// states its class needs. Datapath strobes and mux selects are decoded
// combinationally from the current state and the instruction register.
// FETCH, MEM_RD and MEM_WR stall on mem_ready. A wait-cycle watchdog sends a
// stuck memory access to FAULT. Unknown opcodes or functs also go to FAULT.
// FAULT is sticky until reset.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   instruction[31:0] instruction register contents, valid from DECODE onward
//   mem_ready         memory finished the current read/write this cycle
//   alu_zero/alu_neg  ALU result flags used to resolve branches
//   IRWrite, PCWrite, PCWriteCond, MemRead, MemWrite, RegWrite   strobes
//   PCSource[1:0]     00 ALU, 01 rs (jr), 10 jump target, 11 ALUOut
//   IorD              memory address: 0 PC, 1 ALUOut
//   MemtoReg          1 = writeback from MDR
//   RegDst[1:0]       00 rd, 01 rt, 10 $31
//   ALUSrcA           0 PC, 1 rs
//   ALUSrcB[2:0]      000 rt, 001 4, 010 SExt, 011 SExt<<2, 100 ZExt,
//                     101 upper imm, 110 zero
//   ALU_ctrl[3:0]     0 nop, 1 add, 2 sub, 3 and, 4 or, 5 nor, 6 slt,
//                     7 sll, 8 srl, 9 sra
//   fault             sticky error flag
//   state[3:0]        current state (debug)
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic        mem_ready,
    input  logic        alu_zero,
    input  logic        alu_neg,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic [1:0]  PCSource,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic [1:0]  RegDst,
    output logic        ALUSrcA,
    output logic [2:0]  ALUSrcB,
    output logic [3:0]  ALU_ctrl,
    output logic        fault,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB_MEM   = 4'd7,
        WB_ALU   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        FAULT    = 4'd11
    } state_t;

    // Opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;

    // ALU operations
    localparam logic [3:0] ALU_NOP = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0011;
    localparam logic [3:0] ALU_OR  = 4'b0100;
    localparam logic [3:0] ALU_NOR = 4'b0101;
    localparam logic [3:0] ALU_SLT = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SRA = 4'b1001;

    // ALU B operand selects
    localparam logic [2:0] B_RT    = 3'b000;
    localparam logic [2:0] B_FOUR  = 3'b001;
    localparam logic [2:0] B_SEXT  = 3'b010;
    localparam logic [2:0] B_SEXT2 = 3'b011;
    localparam logic [2:0] B_ZEXT  = 3'b100;
    localparam logic [2:0] B_UPPER = 3'b101;
    localparam logic [2:0] B_ZERO  = 3'b110;

    localparam bit             TIMEOUT_EN = (WAIT_LIMIT != 0);
    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(WAIT_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;

    // Instruction fields
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rt;
    logic       is_nop;
    logic       is_jr;
    logic       is_r_type;

    assign opcode    = instruction[31:26];
    assign funct     = instruction[5:0];
    assign rt        = instruction[20:16];
    assign is_nop    = (instruction == 32'd0);
    assign is_jr     = (funct == F_JR);
    assign is_r_type = (opcode == OP_SPECIAL);

    // R-type ALU decode
    logic       r_valid;
    logic [3:0] r_ctrl;

    always_comb begin
        r_valid = 1'b1;
        r_ctrl  = ALU_NOP;
        case (funct)
            F_SLL:         r_ctrl = ALU_SLL;
            F_SRL:         r_ctrl = ALU_SRL;
            F_SRA:         r_ctrl = ALU_SRA;
            F_ADD, F_ADDU: r_ctrl = ALU_ADD;
            F_SUB, F_SUBU: r_ctrl = ALU_SUB;
            F_AND:         r_ctrl = ALU_AND;
            F_OR:          r_ctrl = ALU_OR;
            F_NOR:         r_ctrl = ALU_NOR;
            F_SLT:         r_ctrl = ALU_SLT;
            default:       r_valid = 1'b0;
        endcase
    end

    // I-type ALU decode
    logic       i_valid;
    logic [2:0] i_srcb;
    logic [3:0] i_ctrl;

    always_comb begin
        i_valid = 1'b1;
        i_srcb  = B_RT;
        i_ctrl  = ALU_NOP;
        case (opcode)
            OP_ANDI:           begin i_srcb = B_ZEXT;  i_ctrl = ALU_AND; end
            OP_ORI:            begin i_srcb = B_ZEXT;  i_ctrl = ALU_OR;  end
            OP_SLTI:           begin i_srcb = B_SEXT;  i_ctrl = ALU_SLT; end
            OP_ADDI, OP_ADDIU: begin i_srcb = B_SEXT;  i_ctrl = ALU_ADD; end
            OP_LUI:            begin i_srcb = B_UPPER; i_ctrl = ALU_ADD; end
            default:           i_valid = 1'b0;
        endcase
    end

    // Branch condition resolved from the ALU flags of rs - rt (or rs - 0)
    logic br_taken;

    always_comb begin
        br_taken = 1'b0;
        case (opcode)
            OP_BEQ:    br_taken = alu_zero;
            OP_BNE:    br_taken = !alu_zero;
            OP_BGTZ:   br_taken = !alu_neg && !alu_zero;
            OP_REGIMM: br_taken = !alu_neg;
            default:   br_taken = 1'b0;
        endcase
    end

    // The watchdog trips only once the counter already holds the limit and
    // memory is still not ready. A ready on that same cycle still completes.
    logic timeout;
    assign timeout = TIMEOUT_EN && !mem_ready && (wait_cnt_reg == LIMIT);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= FETCH;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH: begin
                if (mem_ready)    state_next = DECODE;
                else if (timeout) state_next = FAULT;
            end
            DECODE: begin
                case (opcode)
                    OP_SPECIAL: begin
                        if (is_nop)       state_next = FETCH;
                        else if (is_jr)   state_next = JUMP;
                        else if (r_valid) state_next = EXEC_R;
                        else              state_next = FAULT;
                    end
                    OP_REGIMM:                 state_next = (rt == 5'd1) ? BRANCH : FAULT;
                    OP_BEQ, OP_BNE, OP_BGTZ:   state_next = BRANCH;
                    OP_J, OP_JAL:              state_next = JUMP;
                    OP_LW, OP_SW:              state_next = MEM_ADDR;
                    default:                   state_next = i_valid ? EXEC_I : FAULT;
                endcase
            end
            EXEC_R, EXEC_I: state_next = WB_ALU;
            MEM_ADDR:       state_next = (opcode == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD: begin
                if (mem_ready)    state_next = WB_MEM;
                else if (timeout) state_next = FAULT;
            end
            MEM_WR: begin
                if (mem_ready)    state_next = FETCH;
                else if (timeout) state_next = FAULT;
            end
            WB_MEM, WB_ALU, BRANCH, JUMP: state_next = FETCH;
            FAULT:          state_next = FAULT;
            default:        state_next = FAULT;
        endcase
    end

    // Wait counter: zeroed on any state change so every memory state starts
    // counting from 0. It saturates so a disabled watchdog never wraps.
    logic waiting;
    assign waiting = ((state_reg == FETCH) || (state_reg == MEM_RD) ||
                      (state_reg == MEM_WR)) && !mem_ready;

    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (state_next != state_reg)
            wait_cnt_next = '0;
        else if (waiting && (wait_cnt_reg != CNT_MAX))
            wait_cnt_next = wait_cnt_reg + CNT_ONE;
    end

    // Output decode
    always_comb begin
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 2'b00;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = B_RT;
        ALU_ctrl    = ALU_NOP;
        fault       = 1'b0;

        case (state_reg)
            FETCH: begin
                MemRead  = 1'b1;
                ALUSrcB  = B_FOUR;
                ALU_ctrl = ALU_ADD;
                IRWrite  = mem_ready;
                PCWrite  = mem_ready;
            end
            DECODE: begin
                ALUSrcB  = B_SEXT2;
                ALU_ctrl = ALU_ADD;
            end
            EXEC_R: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = B_RT;
                ALU_ctrl = r_ctrl;
            end
            EXEC_I: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = i_srcb;
                ALU_ctrl = i_ctrl;
            end
            MEM_ADDR: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = B_SEXT;
                ALU_ctrl = ALU_ADD;
            end
            MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            WB_MEM: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                RegDst   = 2'b01;
            end
            WB_ALU: begin
                RegWrite = 1'b1;
                RegDst   = is_r_type ? 2'b00 : 2'b01;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALU_ctrl    = ALU_SUB;
                PCSource    = 2'b11;
                ALUSrcB     = ((opcode == OP_BEQ) || (opcode == OP_BNE)) ? B_RT : B_ZERO;
                PCWriteCond = br_taken;
            end
            JUMP: begin
                PCWrite = 1'b1;
                if (is_r_type) begin
                    PCSource = 2'b01;
                end else begin
                    PCSource = 2'b10;
                    if (opcode == OP_JAL) begin
                        // PC already holds PC+4; pass it through the ALU into $31
                        RegWrite = 1'b1;
                        RegDst   = 2'b10;
                        ALUSrcB  = B_ZERO;
                        ALU_ctrl = ALU_ADD;
                    end
                end
            end
            FAULT: begin
                fault = 1'b1;
            end
            default: begin
                fault = 1'b1;
            end
        endcase

        // Nothing may strobe while reset is held, even though the state
        // register already reads FETCH.
        if (rst) begin
            IRWrite     = 1'b0;
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            PCSource    = 2'b00;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            MemtoReg    = 1'b0;
            RegWrite    = 1'b0;
            RegDst      = 2'b00;
            ALUSrcA     = 1'b0;
            ALUSrcB     = B_RT;
            ALU_ctrl    = ALU_NOP;
            fault       = 1'b0;
        end
    end

    assign state = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//
// Scoreboard bench for multicycle_control. Each stimulus cycle pushes the
// expected output vector for that cycle. A negedge monitor pops it and
// compares it against the observed outputs.
// Observed vector: {state, fault, IRWrite, PCWrite, PCWriteCond, PCSource,
//                   IorD, MemRead, MemWrite, MemtoReg, RegWrite, RegDst,
//                   ALUSrcA, ALUSrcB, ALU_ctrl}
// -----------------------------------------------------------------------------
module tb_multicycle_control;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic        mem_ready;
    logic        alu_zero;
    logic        alu_neg;
    logic        IRWrite, PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
    logic        MemtoReg, RegWrite, ALUSrcA, fault;
    logic [1:0]  PCSource, RegDst;
    logic [2:0]  ALUSrcB;
    logic [3:0]  ALU_ctrl, state;

    multicycle_control #(.WAIT_LIMIT(15), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .mem_ready(mem_ready),
        .alu_zero(alu_zero), .alu_neg(alu_neg), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .RegDst(RegDst),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALU_ctrl(ALU_ctrl),
        .fault(fault), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [24:0] obs;
    assign obs = {state, fault, IRWrite, PCWrite, PCWriteCond, PCSource, IorD,
                  MemRead, MemWrite, MemtoReg, RegWrite, RegDst, ALUSrcA,
                  ALUSrcB, ALU_ctrl};

    int checks = 0;
    int errors = 0;

    logic [24:0] exp_q[$];
    string       tag_q[$];

    task automatic chk(input string tag, input logic [24:0] got, input logic [24:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [24:0] e;
            string       t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk(t, obs, e);
        end
    end

    // Expected-vector builders
    function automatic logic [24:0] pk(
        input logic [3:0] st, input logic flt, input logic irw, input logic pcw,
        input logic pcwc, input logic [1:0] pcs, input logic iord, input logic mr,
        input logic mw, input logic m2r, input logic rw, input logic [1:0] rd,
        input logic asa, input logic [2:0] asb, input logic [3:0] alu);
        return {st, flt, irw, pcw, pcwc, pcs, iord, mr, mw, m2r, rw, rd, asa, asb, alu};
    endfunction

    function automatic logic [24:0] e_fetch(input logic r);
        return pk(4'd0, 0, r, r, 0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 0, 3'b001, 4'b0001);
    endfunction
    function automatic logic [24:0] e_dec();
        return pk(4'd1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 3'b011, 4'b0001);
    endfunction
    function automatic logic [24:0] e_exr(input logic [3:0] a);
        return pk(4'd2, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 3'b000, a);
    endfunction
    function automatic logic [24:0] e_exi(input logic [2:0] b, input logic [3:0] a);
        return pk(4'd3, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1, b, a);
    endfunction
    function automatic logic [24:0] e_wba(input logic [1:0] rd);
        return pk(4'd8, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, rd, 0, 3'b000, 4'b0000);
    endfunction
    function automatic logic [24:0] e_madr();
        return pk(4'd4, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 3'b010, 4'b0001);
    endfunction
    function automatic logic [24:0] e_mrd();
        return pk(4'd5, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0, 0, 2'b00, 0, 3'b000, 4'b0000);
    endfunction
    function automatic logic [24:0] e_mwr();
        return pk(4'd6, 0, 0, 0, 0, 2'b00, 1, 0, 1, 0, 0, 2'b00, 0, 3'b000, 4'b0000);
    endfunction
    function automatic logic [24:0] e_wbm();
        return pk(4'd7, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 2'b01, 0, 3'b000, 4'b0000);
    endfunction
    function automatic logic [24:0] e_br(input logic [2:0] b, input logic c);
        return pk(4'd9, 0, 0, 0, c, 2'b11, 0, 0, 0, 0, 0, 2'b00, 1, b, 4'b0010);
    endfunction
    // k: 0 = j, 1 = jal, 2 = jr
    function automatic logic [24:0] e_jmp(input int k);
        if (k == 1) return pk(4'd10, 0, 0, 1, 0, 2'b10, 0, 0, 0, 0, 1, 2'b10, 0, 3'b110, 4'b0001);
        if (k == 2) return pk(4'd10, 0, 0, 1, 0, 2'b01, 0, 0, 0, 0, 0, 2'b00, 0, 3'b000, 4'b0000);
        return pk(4'd10, 0, 0, 1, 0, 2'b10, 0, 0, 0, 0, 0, 2'b00, 0, 3'b000, 4'b0000);
    endfunction
    function automatic logic [24:0] e_flt();
        return pk(4'd11, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 3'b000, 4'b0000);
    endfunction

    // One clock cycle of stimulus plus its expected outputs
    task automatic step(input logic r, input logic [31:0] ins, input logic rdy,
                        input logic z, input logic n, input logic [24:0] e,
                        input string tag);
        @(posedge clk);
        #1;
        rst         = r;
        instruction = ins;
        mem_ready   = rdy;
        alu_zero    = z;
        alu_neg     = n;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic do_reset();
        $display("txn reset");
        step(1, 32'd0, 0, 0, 0, 25'd0, "reset");
        step(1, 32'd0, 1, 0, 0, 25'd0, "reset_hold");
    endtask

    task automatic alu_ins(input logic [31:0] ins, input logic is_r,
                           input logic [2:0] asb, input logic [3:0] alu, input string tag);
        $display("txn %s ins=%h", tag, ins);
        step(0, ins, 1, 0, 0, e_fetch(1), {tag, "_fetch"});
        step(0, ins, 1, 0, 0, e_dec(), {tag, "_decode"});
        if (is_r) step(0, ins, 1, 0, 0, e_exr(alu), {tag, "_exec"});
        else      step(0, ins, 1, 0, 0, e_exi(asb, alu), {tag, "_exec"});
        step(0, ins, 1, 0, 0, e_wba(is_r ? 2'b00 : 2'b01), {tag, "_wb"});
    endtask

    task automatic br_ins(input logic [31:0] ins, input logic z, input logic n,
                          input logic [2:0] asb, input logic taken, input string tag);
        $display("txn %s ins=%h zero=%0b neg=%0b", tag, ins, z, n);
        step(0, ins, 1, 0, 0, e_fetch(1), {tag, "_fetch"});
        step(0, ins, 1, 0, 0, e_dec(), {tag, "_decode"});
        step(0, ins, 1, z, n, e_br(asb, taken), {tag, "_branch"});
    endtask

    task automatic jmp_ins(input logic [31:0] ins, input int k, input string tag);
        $display("txn %s ins=%h", tag, ins);
        step(0, ins, 1, 0, 0, e_fetch(1), {tag, "_fetch"});
        step(0, ins, 1, 0, 0, e_dec(), {tag, "_decode"});
        step(0, ins, 1, 0, 0, e_jmp(k), {tag, "_jump"});
    endtask

    task automatic bad_ins(input logic [31:0] ins, input string tag);
        $display("txn %s ins=%h", tag, ins);
        step(0, ins, 1, 0, 0, e_fetch(1), {tag, "_fetch"});
        step(0, ins, 1, 0, 0, e_dec(), {tag, "_decode"});
        step(0, ins, 1, 0, 0, e_flt(), {tag, "_fault"});
        step(0, ins, 0, 0, 0, e_flt(), {tag, "_fault_hold"});
    endtask

    initial begin
        rst         = 1'b1;
        instruction = 32'd0;
        mem_ready   = 1'b0;
        alu_zero    = 1'b0;
        alu_neg     = 1'b0;

        do_reset();

        // R-type and I-type ALU instructions
        alu_ins(32'h00221820, 1, 3'b000, 4'b0001, "add");
        alu_ins(32'h00221822, 1, 3'b000, 4'b0010, "sub");
        alu_ins(32'h00221821, 1, 3'b000, 4'b0001, "addu");
        alu_ins(32'h00221823, 1, 3'b000, 4'b0010, "subu");
        alu_ins(32'h00221824, 1, 3'b000, 4'b0011, "and");
        alu_ins(32'h00221825, 1, 3'b000, 4'b0100, "or");
        alu_ins(32'h00221827, 1, 3'b000, 4'b0101, "nor");
        alu_ins(32'h0022182A, 1, 3'b000, 4'b0110, "slt");
        alu_ins(32'h00021840, 1, 3'b000, 4'b0111, "sll");
        alu_ins(32'h00021842, 1, 3'b000, 4'b1000, "srl");
        alu_ins(32'h00021843, 1, 3'b000, 4'b1001, "sra");
        alu_ins(32'h30220005, 0, 3'b100, 4'b0011, "andi");
        alu_ins(32'h34220055, 0, 3'b100, 4'b0100, "ori");
        alu_ins(32'h28220005, 0, 3'b010, 4'b0110, "slti");
        alu_ins(32'h20220005, 0, 3'b010, 4'b0001, "addi");
        alu_ins(32'h24220005, 0, 3'b010, 4'b0001, "addiu");
        alu_ins(32'h3C011234, 0, 3'b101, 4'b0001, "lui");

        // lw with three not-ready cycles in MEM_RD: 8 cycles total
        $display("txn lw_wait3 ins=8c850008");
        step(0, 32'h8C850008, 1, 0, 0, e_fetch(1), "lw_fetch");
        step(0, 32'h8C850008, 1, 0, 0, e_dec(), "lw_decode");
        step(0, 32'h8C850008, 1, 0, 0, e_madr(), "lw_addr");
        for (int i = 0; i < 3; i++)
            step(0, 32'h8C850008, 0, 0, 0, e_mrd(), "lw_rd_wait");
        step(0, 32'h8C850008, 1, 0, 0, e_mrd(), "lw_rd_done");
        step(0, 32'h8C850008, 1, 0, 0, e_wbm(), "lw_wb");

        // Branches
        br_ins(32'h10220005, 1, 0, 3'b000, 1, "beq_taken");
        br_ins(32'h10220005, 0, 0, 3'b000, 0, "beq_not");
        br_ins(32'h14220005, 0, 0, 3'b000, 1, "bne_taken");
        br_ins(32'h14220005, 1, 0, 3'b000, 0, "bne_not");
        br_ins(32'h1C200005, 0, 1, 3'b110, 0, "bgtz_neg");
        br_ins(32'h1C200005, 1, 0, 3'b110, 0, "bgtz_zero");
        br_ins(32'h1C200005, 0, 0, 3'b110, 1, "bgtz_taken");
        br_ins(32'h04210005, 1, 0, 3'b110, 1, "bgez_zero");
        br_ins(32'h04210005, 0, 1, 3'b110, 0, "bgez_neg");

        // Jumps
        jmp_ins(32'h0C100000, 1, "jal");
        jmp_ins(32'h08100000, 0, "j");
        jmp_ins(32'h03E00008, 2, "jr");

        // nop returns to FETCH straight from DECODE
        $display("txn nop ins=00000000");
        step(0, 32'h00000000, 1, 0, 0, e_fetch(1), "nop_fetch");
        step(0, 32'h00000000, 1, 0, 0, e_dec(), "nop_decode");

        // Fetch stall then an instruction; sw with one wait cycle
        $display("txn fetch_stall");
        step(0, 32'h00221820, 0, 0, 0, e_fetch(0), "stall_fetch");
        step(0, 32'h00221820, 0, 0, 0, e_fetch(0), "stall_fetch");
        alu_ins(32'h00221820, 1, 3'b000, 4'b0001, "add_after_stall");
        $display("txn sw ins=ac850008");
        step(0, 32'hAC850008, 1, 0, 0, e_fetch(1), "sw_fetch");
        step(0, 32'hAC850008, 1, 0, 0, e_dec(), "sw_decode");
        step(0, 32'hAC850008, 1, 0, 0, e_madr(), "sw_addr");
        step(0, 32'hAC850008, 0, 0, 0, e_mwr(), "sw_wr_wait");
        step(0, 32'hAC850008, 1, 0, 0, e_mwr(), "sw_wr_done");

        // lw: ready arrives on the limit cycle, so it must still complete
        $display("txn lw_limit_ready");
        step(0, 32'h8C850008, 1, 0, 0, e_fetch(1), "lwlim_fetch");
        step(0, 32'h8C850008, 1, 0, 0, e_dec(), "lwlim_decode");
        step(0, 32'h8C850008, 1, 0, 0, e_madr(), "lwlim_addr");
        for (int i = 0; i < 15; i++)
            step(0, 32'h8C850008, 0, 0, 0, e_mrd(), "lwlim_wait");
        step(0, 32'h8C850008, 1, 0, 0, e_mrd(), "lwlim_ready_on_limit");
        step(0, 32'h8C850008, 1, 0, 0, e_wbm(), "lwlim_wb");

        // sw: memory never ready -> FAULT, sticky even when ready returns
        $display("txn sw_timeout");
        step(0, 32'hAC850008, 1, 0, 0, e_fetch(1), "swto_fetch");
        step(0, 32'hAC850008, 1, 0, 0, e_dec(), "swto_decode");
        step(0, 32'hAC850008, 1, 0, 0, e_madr(), "swto_addr");
        for (int i = 0; i < 16; i++)
            step(0, 32'hAC850008, 0, 0, 0, e_mwr(), "swto_wait");
        step(0, 32'hAC850008, 1, 0, 0, e_flt(), "swto_fault");
        step(0, 32'hAC850008, 1, 0, 0, e_flt(), "swto_fault_hold");
        do_reset();

        // FETCH watchdog: 15 counted waits, FAULT on the next not-ready cycle
        $display("txn fetch_timeout");
        for (int i = 0; i < 16; i++)
            step(0, 32'h00221820, 0, 0, 0, e_fetch(0), "fto_wait");
        step(0, 32'h00221820, 0, 0, 0, e_flt(), "fto_fault");
        step(0, 32'h00221820, 1, 0, 0, e_flt(), "fto_fault_hold");
        do_reset();

        // Illegal encodings
        bad_ins(32'hFC000000, "bad_opcode");
        do_reset();
        bad_ins(32'h00000001, "bad_funct");
        do_reset();
        bad_ins(32'h04220005, "bad_regimm_rt");
        do_reset();

        // Reset in the middle of a store
        $display("txn reset_in_mem_wr");
        step(0, 32'hAC850008, 1, 0, 0, e_fetch(1), "rstw_fetch");
        step(0, 32'hAC850008, 1, 0, 0, e_dec(), "rstw_decode");
        step(0, 32'hAC850008, 1, 0, 0, e_madr(), "rstw_addr");
        step(0, 32'hAC850008, 0, 0, 0, e_mwr(), "rstw_wr_wait");
        step(1, 32'hAC850008, 1, 0, 0, 25'd0, "rstw_reset_drop");
        alu_ins(32'h00221820, 1, 3'b000, 4'b0001, "add_after_reset");

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
